pc_sequencer: RTL and testbench

- Next-PC controller for the single-cycle core; sits directly in front of the program counter register.
- Each cycle it picks the value the PC register loads on the next edge: reset vector, PC+4, branch/jump target, trap vector, EPC or hold.
- Owns a small run-state FSM (boot, run, trap, halt) and the EPC/cause registers for the basic machine-mode trap path.
- The PC register has no enable; this block implements stall and halt by feeding `pc_in` back as `pc_next`.

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/pc_target_check.sv | 28 ++
 rtl/pc_sequencer.sv | 144 ++++++++++++++
 tb/tb_pc_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the next-PC sequencer
// Contents: run-state enum, trap cause codes, default vector/boot parameters.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2,
    HALT = 2'd3
  } pc_state_t;

  localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_BREAK    = 4'd3;
  localparam logic [3:0] CAUSE_ECALL    = 4'd11;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int unsigned DEFAULT_BOOT_CYCLES  = 4;

endpackage

// File: rtl/pc_target_check.sv
// rtl/pc_target_check.sv - effective jump target and misaligned-target detection
// Ports:
//   jump, jalr, jump_target   : jump request, JALR qualifier, raw target
//   branch_taken, branch_lo   : taken branch and the low two bits of its target
//   jump_eff                  : jump target with bit 0 cleared for JALR
//   misaligned                : the target actually chosen is not word aligned
module pc_target_check (
  input  logic        jump,
  input  logic        jalr,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [1:0]  branch_lo,
  output logic [31:0] jump_eff,
  output logic        misaligned
);

  always_comb begin
    jump_eff   = jalr ? {jump_target[31:1], 1'b0} : jump_target;
    misaligned = 1'b0;
    // Jump outranks branch, so only the jump's target matters when both fire.
    if (jump) begin
      misaligned = |jump_eff[1:0];
    end else if (branch_taken) begin
      misaligned = |branch_lo;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection, run-state FSM and EPC/cause registers
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   pc_in, stall                       : current PC, freeze request
//   branch_taken/branch_target         : resolved conditional branch
//   jump/jalr/jump_target              : JAL/JALR request and raw target
//   ecall, ebreak, mret, resume        : trap, halt, return and un-halt requests
//   pc_next, pc_plus4                  : PC register load value, link value
//   fetch_valid, epc, mcause, halted   : commit enable, trap state, halt flag
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
  parameter int unsigned BOOT_CYCLES  = DEFAULT_BOOT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic        jalr,
  input  logic [31:0] jump_target,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        mret,
  input  logic        resume,
  output logic [31:0] pc_next,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic [31:0] epc,
  output logic [3:0]  mcause,
  output logic        halted
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  pc_state_t   state, state_next;
  logic [3:0]  boot_count, boot_count_next;
  logic [31:0] epc_next;
  logic [3:0]  mcause_next;
  logic [31:0] jump_eff;
  logic        misaligned;

  assign pc_plus4 = pc_in + 32'd4;

  pc_target_check u_target_check (
    .jump         (jump),
    .jalr         (jalr),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_lo    (branch_target[1:0]),
    .jump_eff     (jump_eff),
    .misaligned   (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      boot_count <= 4'd0;
      epc        <= 32'd0;
      mcause     <= 4'd0;
    end else begin
      state      <= state_next;
      boot_count <= boot_count_next;
      epc        <= epc_next;
      mcause     <= mcause_next;
    end
  end

  always_comb begin
    state_next      = state;
    boot_count_next = boot_count;
    epc_next        = epc;
    mcause_next     = mcause;
    pc_next         = pc_plus4;
    fetch_valid     = 1'b0;
    halted          = 1'b0;

    case (state)
      BOOT: begin
        pc_next = RESET_VECTOR;
        if (boot_count == BOOT_LAST) begin
          state_next = RUN;
        end else begin
          boot_count_next = boot_count + 4'd1;
        end
      end
      RUN: begin
        fetch_valid = !stall;
        if (stall) begin
          pc_next = pc_in;
        end else if (misaligned) begin
          epc_next    = pc_in;
          mcause_next = CAUSE_MISALIGN;
          pc_next     = TRAP_VECTOR;
          state_next  = TRAP;
        end else if (ecall) begin
          epc_next    = pc_in;
          mcause_next = CAUSE_ECALL;
          pc_next     = TRAP_VECTOR;
          state_next  = TRAP;
        end else if (ebreak) begin
          epc_next    = pc_in;
          mcause_next = CAUSE_BREAK;
          pc_next     = pc_in;
          state_next  = HALT;
        end else if (mret) begin
          pc_next = epc + 32'd4;
        end else if (jump) begin
          pc_next = jump_eff;
        end else if (branch_taken) begin
          pc_next = branch_target;
        end
      end
      TRAP: begin
        // Handler's first instruction always commits; nothing can redirect it.
        fetch_valid = 1'b1;
        state_next  = RUN;
      end
      HALT: begin
        halted = 1'b1;
        if (resume) begin
          state_next = RUN;
        end else begin
          pc_next = pc_in;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase

    // Reset overrides the visible outputs in the same cycle it is asserted.
    if (reset) begin
      pc_next     = RESET_VECTOR;
      fetch_valid = 1'b0;
      halted      = 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic        jalr;
  logic [31:0] jump_target;
  logic        ecall;
  logic        ebreak;
  logic        mret;
  logic        resume;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic [31:0] epc;
  logic [3:0]  mcause;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (pc_in),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jalr          (jalr),
    .jump_target   (jump_target),
    .ecall         (ecall),
    .ebreak        (ebreak),
    .mret          (mret),
    .resume        (resume),
    .pc_next       (pc_next),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .epc           (epc),
    .mcause        (mcause),
    .halted        (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    stall = 0; branch_taken = 0; branch_target = 0; jump = 0; jalr = 0;
    jump_target = 0; ecall = 0; ebreak = 0; mret = 0; resume = 0;
  endtask

  task automatic test_reset();
    clear_events();
    reset = 1; pc_in = 32'h40;
    step(); step();
    n_checks++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL reset_pc_next: got %h want %h", pc_next, 32'h0); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_valid: got %b want 0", fetch_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_checks++; if (epc !== 32'h0 || mcause !== 4'd0) begin n_fail++; $display("FAIL reset_regs: epc=%h mcause=%0d want 0/0", epc, mcause); end
    reset = 0;
    ecall = 1; jump = 1; jump_target = 32'h80;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (pc_next !== 32'h0 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL boot_cycle%0d: pc_next=%h fv=%b want 0/0", i, pc_next, fetch_valid); end
      step();
    end
    clear_events(); pc_in = 32'h0; #1;
    n_checks++; if (pc_next !== 32'h4 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL boot_to_run: pc_next=%h fv=%b want 4/1", pc_next, fetch_valid); end
    n_checks++; if (epc !== 32'h0) begin n_fail++; $display("FAIL boot_ignores_ecall: epc=%h want 0", epc); end
    step();
  endtask

  task automatic test_jump_branch();
    clear_events();
    pc_in = 32'h40; branch_taken = 1; branch_target = 32'h60; jump = 1; jump_target = 32'h80; #1;
    n_checks++; if (pc_next !== 32'h80) begin n_fail++; $display("FAIL jump_beats_branch: got %h want %h", pc_next, 32'h80); end
    n_checks++; if (pc_plus4 !== 32'h44) begin n_fail++; $display("FAIL pc_plus4: got %h want %h", pc_plus4, 32'h44); end
    jump = 0; #1;
    n_checks++; if (pc_next !== 32'h60) begin n_fail++; $display("FAIL branch_taken: got %h want %h", pc_next, 32'h60); end
    clear_events(); pc_in = 32'hFFFF_FFFC; #1;
    n_checks++; if (pc_next !== 32'h0 || pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap: pc_next=%h pc_plus4=%h want 0/0", pc_next, pc_plus4); end
    step();
  endtask

  task automatic test_jalr_misalign();
    clear_events();
    pc_in = 32'h40; jump = 1; jalr = 1; jump_target = 32'h81; #1;
    n_checks++; if (pc_next !== 32'h80) begin n_fail++; $display("FAIL jalr_clear_bit0: got %h want %h", pc_next, 32'h80); end
    jump_target = 32'h82; #1;
    n_checks++; if (pc_next !== 32'h100) begin n_fail++; $display("FAIL misalign_vector: got %h want %h", pc_next, 32'h100); end
    step();
    n_checks++; if (epc !== 32'h40 || mcause !== 4'd0) begin n_fail++; $display("FAIL misalign_regs: epc=%h mcause=%0d want 40/0", epc, mcause); end
    clear_events(); pc_in = 32'h100; stall = 1; ecall = 1; #1;
    n_checks++; if (pc_next !== 32'h104 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL trap_state: pc_next=%h fv=%b want 104/1", pc_next, fetch_valid); end
    step();
    n_checks++; if (epc !== 32'h40) begin n_fail++; $display("FAIL trap_ignores_ecall: epc=%h want 40", epc); end
    ecall = 0; pc_in = 32'h104; #1;
    n_checks++; if (pc_next !== 32'h104 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL trap_back_to_run: pc_next=%h fv=%b want 104/0", pc_next, fetch_valid); end
    step();
  endtask

  task automatic test_ecall_mret();
    clear_events();
    pc_in = 32'h200; ecall = 1; mret = 1; #1;
    n_checks++; if (pc_next !== 32'h100) begin n_fail++; $display("FAIL ecall_vector: got %h want %h", pc_next, 32'h100); end
    step();
    n_checks++; if (mcause !== 4'd11 || epc !== 32'h200) begin n_fail++; $display("FAIL ecall_regs: epc=%h mcause=%0d want 200/11", epc, mcause); end
    clear_events(); pc_in = 32'h100;
    step();
    pc_in = 32'h104; mret = 1; jump = 1; jump_target = 32'h80; #1;
    n_checks++; if (pc_next !== 32'h204) begin n_fail++; $display("FAIL mret_return: got %h want %h", pc_next, 32'h204); end
    step();
  endtask

  task automatic test_ebreak_halt();
    clear_events();
    pc_in = 32'h300; ebreak = 1; #1;
    n_checks++; if (pc_next !== 32'h300) begin n_fail++; $display("FAIL ebreak_hold: got %h want %h", pc_next, 32'h300); end
    step();
    ebreak = 0;
    n_checks++; if (mcause !== 4'd3 || epc !== 32'h300) begin n_fail++; $display("FAIL ebreak_regs: epc=%h mcause=%0d want 300/3", epc, mcause); end
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (pc_next !== 32'h300 || halted !== 1'b1 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL halt_cycle%0d: pc_next=%h halted=%b fv=%b want 300/1/0", i, pc_next, halted, fetch_valid); end
      step();
    end
    resume = 1; stall = 1; #1;
    n_checks++; if (pc_next !== 32'h304) begin n_fail++; $display("FAIL resume_pc: got %h want %h", pc_next, 32'h304); end
    step();
    clear_events(); pc_in = 32'h304; #1;
    n_checks++; if (halted !== 1'b0 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL resume_run: halted=%b fv=%b want 0/1", halted, fetch_valid); end
  endtask

  task automatic test_stall();
    clear_events();
    pc_in = 32'h10; stall = 1; branch_taken = 1; branch_target = 32'h50; #1;
    n_checks++; if (pc_next !== 32'h10 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold: pc_next=%h fv=%b want 10/0", pc_next, fetch_valid); end
    ecall = 1;
    step();
    n_checks++; if (mcause !== 4'd3 || epc !== 32'h300) begin n_fail++; $display("FAIL stall_no_update: epc=%h mcause=%0d want 300/3", epc, mcause); end
    stall = 0; branch_taken = 0; ecall = 0; #1;
    n_checks++; if (pc_next !== 32'h14) begin n_fail++; $display("FAIL stall_release: got %h want %h", pc_next, 32'h14); end
    step();
  endtask

  task automatic test_reset_mid_halt();
    clear_events();
    pc_in = 32'h400; ebreak = 1;
    step();
    ebreak = 0; #1;
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL pre_reset_halt: halted=%b want 1", halted); end
    reset = 1; #1;
    n_checks++; if (halted !== 1'b0 || pc_next !== 32'h0) begin n_fail++; $display("FAIL reset_override: halted=%b pc_next=%h want 0/0", halted, pc_next); end
    step();
    reset = 0; resume = 1; #1;
    n_checks++; if (halted !== 1'b0 || epc !== 32'h0 || mcause !== 4'd0) begin n_fail++; $display("FAIL reset_mid_halt: halted=%b epc=%h mcause=%0d want 0/0/0", halted, epc, mcause); end
    n_checks++; if (pc_next !== 32'h0 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_to_boot: pc_next=%h fv=%b want 0/0", pc_next, fetch_valid); end
    step();
  endtask

  initial begin
    test_reset();
    test_jump_branch();
    test_jalr_misalign();
    test_ecall_mret();
    test_ebreak_halt();
    test_stall();
    test_reset_mid_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
